axi4_lite_gpu_fill_engine: RTL and testbench



---
 rtl/axi4_lite_gpu_pkg.sv | 29 ++
 rtl/axi4_lite_gpu_fill_engine_walker.sv | 85 ++++++++
 rtl/axi4_lite_gpu_fill_engine.sv | 213 +++++++++++++++++++++
 tb/tb_axi4_lite_gpu_fill_engine.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_gpu_pkg.sv
// Shared constants for the GPU fill engine: register offsets, CTRL/STATUS bit
// positions, version word and the fill FSM state type.
package axi4_lite_gpu_pkg;

  localparam logic [31:0] REG_STATUS  = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL    = 32'h0000_0004;
  localparam logic [31:0] REG_COLOR   = 32'h0000_0008;
  localparam logic [31:0] REG_RECT_XY = 32'h0000_000C;
  localparam logic [31:0] REG_RECT_WH = 32'h0000_0010;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_ABORT  = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;
  localparam int unsigned STATUS_ERR  = 2;

  localparam logic [15:0] GPU_VERSION   = 16'h0002;
  localparam logic [31:0] RESP_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/axi4_lite_gpu_fill_engine_walker.sv
// Rectangle walker: x/y counters and row_base accumulator producing one pixel
// address per step. Clipping to the framebuffer is enabled by GPU_FILL_CLIP_EN.
module gpu_rect_fill_walker #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FB_WIDTH        = 640,
  parameter int unsigned FB_HEIGHT       = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  input  logic [15:0]                x0,
  input  logic [15:0]                y0,
  input  logic [15:0]                w,
  input  logic [15:0]                h,
  output logic [FBUF_ADDR_WIDTH-1:0] addr,
  output logic                       last,
  output logic                       empty,
  output logic                       reject
);

  logic [16:0]                x_end, y_end;
  logic                       x_over, y_over;
  logic [15:0]                eff_w, eff_h;
  logic [31:0]                start_lin;
  logic [FBUF_ADDR_WIDTH-1:0] row_base;
  logic [15:0]                x_off, y_off, w_s, h_s;
  logic                       row_last;

  assign x_end  = {1'b0, x0} + {1'b0, w};
  assign y_end  = {1'b0, y0} + {1'b0, h};
  assign x_over = x_end > 17'(FB_WIDTH);
  assign y_over = y_end > 17'(FB_HEIGHT);

`ifdef GPU_FILL_CLIP_EN
  always_comb begin
    eff_w = w;
    if (x0 >= 16'(FB_WIDTH))  eff_w = '0;
    else if (x_over)          eff_w = 16'(FB_WIDTH) - x0;
    eff_h = h;
    if (y0 >= 16'(FB_HEIGHT)) eff_h = '0;
    else if (y_over)          eff_h = 16'(FB_HEIGHT) - y0;
  end
  assign reject = 1'b0;
`else
  assign eff_w  = w;
  assign eff_h  = h;
  assign reject = x_over | y_over;
`endif

  assign empty = (eff_w == '0) || (eff_h == '0);

  // Constant-coefficient product, only evaluated once at load; the walk
  // itself advances row_base by addition.
  assign start_lin = 32'(y0) * 32'(FB_WIDTH) + 32'(x0);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_base <= '0;
      x_off    <= '0;
      y_off    <= '0;
      w_s      <= '0;
      h_s      <= '0;
    end else if (load) begin
      row_base <= FBUF_ADDR_WIDTH'(start_lin);
      x_off    <= '0;
      y_off    <= '0;
      w_s      <= eff_w;
      h_s      <= eff_h;
    end else if (step) begin
      if (row_last) begin
        x_off    <= '0;
        y_off    <= y_off + 16'd1;
        row_base <= row_base + FBUF_ADDR_WIDTH'(FB_WIDTH);
      end else begin
        x_off <= x_off + 16'd1;
      end
    end
  end

  assign row_last = (x_off == w_s - 16'd1);
  assign last     = row_last && (y_off == h_s - 16'd1);
  assign addr     = row_base + FBUF_ADDR_WIDTH'(x_off);

endmodule

// File: rtl/axi4_lite_gpu_fill_engine.sv
// AXI4-Lite back-end with register file, direct pixel window and rectangle
// fill engine driving the framebuffer BRAM. Optional clipping: GPU_FILL_CLIP_EN.
module axi4_lite_gpu_fill_engine
  import axi4_lite_gpu_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned FBUF_ADDR_WIDTH   = 19,
  parameter int unsigned FBUF_DATA_WIDTH   = 8,
  parameter int unsigned FB_WIDTH          = 640,
  parameter int unsigned FB_HEIGHT         = 480,
  parameter logic [31:0] PIX_BASE          = 32'h0008_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_processing_start,
  input  logic [AXI_ADDRESS_WIDTH-1:0] read_address,
  output logic [AXI_DATA_WIDTH-1:0]    read_data,
  output logic                         read_processing_done,
  output logic                         read_resp_ok,
  input  logic                         write_processing_start,
  input  logic [AXI_ADDRESS_WIDTH-1:0] write_address,
  input  logic [AXI_DATA_WIDTH-1:0]    write_data,
  output logic                         write_processing_ok,
  output logic                         write_processing_done,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
  output logic                         irq
);

  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [AXI_ADDRESS_WIDTH-1:0] PIX_BASE_A = AXI_ADDRESS_WIDTH'(PIX_BASE);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] A_STATUS   = AXI_ADDRESS_WIDTH'(REG_STATUS);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] A_CTRL     = AXI_ADDRESS_WIDTH'(REG_CTRL);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] A_COLOR    = AXI_ADDRESS_WIDTH'(REG_COLOR);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] A_RECT_XY  = AXI_ADDRESS_WIDTH'(REG_RECT_XY);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] A_RECT_WH  = AXI_ADDRESS_WIDTH'(REG_RECT_WH);

  fill_state_t                  state;
  logic                         rd_start_q, wr_start_q, rd_edge, wr_edge;
  logic [FBUF_DATA_WIDTH-1:0]   color, color_s;
  logic [15:0]                  rect_x0, rect_y0, rect_w, rect_h;
  logic                         irq_en, sts_done, sts_err, busy;
  logic                         rd_is_pix, wr_is_pix, pix_in_range, ctrl_wr, fill_launch;
  logic [AXI_ADDRESS_WIDTH-1:0] wr_off;
  logic [FBUF_ADDR_WIDTH-1:0]   walk_addr;
  logic                         walk_last, walk_empty, walk_reject;
  logic [AXI_DATA_WIDTH-1:0]    status_word, rd_word;
  logic                         rd_ok;

  assign rd_edge      = read_processing_start & ~rd_start_q;
  assign wr_edge      = write_processing_start & ~wr_start_q;
  assign busy         = (state != ST_IDLE);
  assign rd_is_pix    = (read_address >= PIX_BASE_A);
  assign wr_is_pix    = (write_address >= PIX_BASE_A);
  assign wr_off       = write_address - PIX_BASE_A;
  assign pix_in_range = (wr_off < AXI_ADDRESS_WIDTH'(FB_PIXELS));
  assign ctrl_wr      = wr_edge && !wr_is_pix && (write_address == A_CTRL);
  assign fill_launch  = ctrl_wr && write_data[CTRL_START] && !busy && !walk_empty && !walk_reject;
  assign irq          = sts_done & irq_en;

  assign status_word = AXI_DATA_WIDTH'({GPU_VERSION, 13'h0, sts_err, sts_done, busy});

  gpu_rect_fill_walker #(
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .FB_WIDTH        (FB_WIDTH),
    .FB_HEIGHT       (FB_HEIGHT)
  ) u_walker (
    .clk    (clk),
    .rst    (rst),
    .load   (fill_launch),
    .step   (state == ST_FILL),
    .x0     (rect_x0),
    .y0     (rect_y0),
    .w      (rect_w),
    .h      (rect_h),
    .addr   (walk_addr),
    .last   (walk_last),
    .empty  (walk_empty),
    .reject (walk_reject)
  );

  always_comb begin
    rd_word = AXI_DATA_WIDTH'(RESP_ERR_DATA);
    rd_ok   = 1'b0;
    if (!rd_is_pix) begin
      rd_ok = 1'b1;
      case (read_address)
        A_STATUS:  rd_word = status_word;
        A_CTRL:    rd_word = AXI_DATA_WIDTH'({irq_en, 3'b000});
        A_COLOR:   rd_word = AXI_DATA_WIDTH'(color);
        A_RECT_XY: rd_word = AXI_DATA_WIDTH'({rect_y0, rect_x0});
        A_RECT_WH: rd_word = AXI_DATA_WIDTH'({rect_h, rect_w});
        default: begin
          rd_word = AXI_DATA_WIDTH'(RESP_ERR_DATA);
          rd_ok   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      rd_start_q            <= 1'b0;
      wr_start_q            <= 1'b0;
      read_data             <= '0;
      read_processing_done  <= 1'b0;
      read_resp_ok          <= 1'b0;
      write_processing_done <= 1'b0;
      write_processing_ok   <= 1'b0;
      fbuf_en_wr            <= 1'b0;
      fbuf_wrea             <= 1'b0;
      fbuf_addr             <= '0;
      fbuf_data             <= '0;
      color                 <= '0;
      color_s               <= '0;
      rect_x0               <= '0;
      rect_y0               <= '0;
      rect_w                <= '0;
      rect_h                <= '0;
      irq_en                <= 1'b0;
      sts_done              <= 1'b0;
      sts_err               <= 1'b0;
    end else begin
      rd_start_q            <= read_processing_start;
      wr_start_q            <= write_processing_start;
      read_processing_done  <= 1'b0;
      read_resp_ok          <= 1'b0;
      read_data             <= '0;
      write_processing_done <= 1'b0;
      write_processing_ok   <= 1'b0;
      fbuf_en_wr            <= 1'b0;
      fbuf_wrea             <= 1'b0;
      fbuf_addr             <= '0;
      fbuf_data             <= '0;

      case (state)
        ST_FILL: begin
          fbuf_en_wr <= 1'b1;
          fbuf_wrea  <= 1'b1;
          fbuf_addr  <= walk_addr;
          fbuf_data  <= color_s;
          if (walk_last) state <= ST_DONE;
        end
        ST_DONE: begin
          sts_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: ;
      endcase

      if (fill_launch) color_s <= color;

      if (rd_edge) begin
        read_processing_done <= 1'b1;
        read_resp_ok         <= rd_ok;
        read_data            <= rd_word;
      end

      if (wr_edge) begin
        write_processing_done <= 1'b1;
        if (wr_is_pix) begin
          if (!busy && pix_in_range) begin
            fbuf_en_wr          <= 1'b1;
            fbuf_wrea           <= 1'b1;
            fbuf_addr           <= FBUF_ADDR_WIDTH'(wr_off);
            fbuf_data           <= write_data[FBUF_DATA_WIDTH-1:0];
            write_processing_ok <= 1'b1;
          end
        end else begin
          case (write_address)
            A_CTRL: begin
              write_processing_ok <= 1'b1;
              irq_en              <= write_data[CTRL_IRQ_EN];
              // Clear lands before the start outcome so a failing start in the
              // same write still leaves err set.
              if (write_data[CTRL_CLEAR]) begin
                sts_done <= 1'b0;
                sts_err  <= 1'b0;
              end
              if (state == ST_FILL && write_data[CTRL_ABORT]) begin
                state <= ST_IDLE;
              end else if (write_data[CTRL_START]) begin
                if (busy || (!walk_empty && walk_reject)) sts_err <= 1'b1;
                else if (walk_empty)                       state   <= ST_DONE;
                else                                       state   <= ST_FILL;
              end
            end
            A_COLOR: begin
              color               <= write_data[FBUF_DATA_WIDTH-1:0];
              write_processing_ok <= 1'b1;
            end
            A_RECT_XY: begin
              rect_x0             <= write_data[15:0];
              rect_y0             <= write_data[31:16];
              write_processing_ok <= 1'b1;
            end
            A_RECT_WH: begin
              rect_w              <= write_data[15:0];
              rect_h              <= write_data[31:16];
              write_processing_ok <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_gpu_fill_engine.sv
// Directed self-checking bench for axi4_lite_gpu_fill_engine (honours GPU_FILL_CLIP_EN).
module tb_axi4_lite_gpu_fill_engine;

  localparam logic [31:0] PIX = 32'h0008_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_processing_start;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_processing_done;
  logic        read_resp_ok;
  logic        write_processing_start;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        write_processing_ok;
  logic        write_processing_done;
  logic        fbuf_en_wr;
  logic        fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;
  logic        irq;

  int checks = 0;
  int passed = 0;
  logic [18:0] q_addr[$];
  logic [7:0]  q_data[$];

  always #5 clk = ~clk;

  axi4_lite_gpu_fill_engine #(
    .AXI_ADDRESS_WIDTH (32),
    .AXI_DATA_WIDTH    (32),
    .FBUF_ADDR_WIDTH   (19),
    .FBUF_DATA_WIDTH   (8),
    .FB_WIDTH          (640),
    .FB_HEIGHT         (480),
    .PIX_BASE          (PIX)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .read_processing_start  (read_processing_start),
    .read_address           (read_address),
    .read_data              (read_data),
    .read_processing_done   (read_processing_done),
    .read_resp_ok           (read_resp_ok),
    .write_processing_start (write_processing_start),
    .write_address          (write_address),
    .write_data             (write_data),
    .write_processing_ok    (write_processing_ok),
    .write_processing_done  (write_processing_done),
    .fbuf_en_wr             (fbuf_en_wr),
    .fbuf_wrea              (fbuf_wrea),
    .fbuf_addr              (fbuf_addr),
    .fbuf_data              (fbuf_data),
    .irq                    (irq)
  );

  always @(negedge clk) begin
    if (fbuf_en_wr === 1'b1 && fbuf_wrea === 1'b1) begin
      q_addr.push_back(fbuf_addr);
      q_data.push_back(fbuf_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
    bit got = 0;
    ok = 1'bx;
    @(negedge clk);
    write_address = a;
    write_data = d;
    write_processing_start = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (write_processing_done === 1'b1) begin
        got = 1;
        ok = write_processing_ok;
      end
    end
    write_processing_start = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL write_timeout addr=%h got no done, required done", a);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
    bit got = 0;
    ok = 1'bx;
    d = 'x;
    @(negedge clk);
    read_address = a;
    read_processing_start = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (read_processing_done === 1'b1) begin
        got = 1;
        ok = read_resp_ok;
        d = read_data;
      end
    end
    read_processing_start = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL read_timeout addr=%h got no done, required done", a);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic ok;
    rst = 1'b1;
    read_processing_start = 1'b0;
    write_processing_start = 1'b0;
    read_address = '0;
    write_address = '0;
    write_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, read_processing_done, write_processing_done,
         read_data, read_resp_ok, write_processing_ok, irq} !== '0)
      $display("FAIL reset_outputs got en=%b addr=%0d rd=%h irq=%b, required all 0",
               fbuf_en_wr, fbuf_addr, read_data, irq);
    else passed++;
    rst = 1'b0;
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0000 || ok !== 1'b1)
      $display("FAIL reset_status got %h/%b, required 00020000/1", d, ok);
    else passed++;
  endtask

  task automatic test_fill;
    logic [31:0] d;
    logic ok;
    logic [18:0] exp_a[6];
    exp_a = '{19'd642, 19'd643, 19'd644, 19'd1282, 19'd1283, 19'd1284};
    bus_write(32'h08, 32'h0000_005A, ok);
    bus_write(32'h0C, 32'h0001_0002, ok);
    bus_write(32'h10, 32'h0002_0003, ok);
    q_addr.delete();
    q_data.delete();
    bus_write(32'h04, 32'h1, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL fill_start_ok got %b, required 1", ok);
    else passed++;
    idle(20);
    checks++;
    if (q_addr.size() != 6) $display("FAIL fill_count got %0d, required 6", q_addr.size());
    else passed++;
    if (q_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q_addr[i] !== exp_a[i] || q_data[i] !== 8'h5A)
          $display("FAIL fill_pixel%0d got %0d/%h, required %0d/5a", i, q_addr[i], q_data[i], exp_a[i]);
        else passed++;
      end
    end
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0002) $display("FAIL fill_status got %h, required 00020002", d);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_disabled got %b, required 0", irq);
    else passed++;
    bus_write(32'h04, 32'h8, ok);
    checks++;
    if (irq !== 1'b1) $display("FAIL irq_enabled got %b, required 1", irq);
    else passed++;
    bus_read(32'h04, d, ok);
    checks++;
    if (d !== 32'h8 || ok !== 1'b1) $display("FAIL ctrl_read got %h/%b, required 00000008/1", d, ok);
    else passed++;
    bus_write(32'h04, 32'h2, ok);
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0000 || irq !== 1'b0)
      $display("FAIL clear_done got %h irq=%b, required 00020000 irq=0", d, irq);
    else passed++;
  endtask

  task automatic test_pixel;
    logic [31:0] d;
    logic ok;
    q_addr.delete();
    q_data.delete();
    bus_write(PIX + 32'd307200, 32'h11, ok);
    checks++;
    if (ok !== 1'b0) $display("FAIL pix_oob_ok got %b, required 0", ok);
    else passed++;
    bus_write(PIX + 32'd5, 32'hA7, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL pix5_ok got %b, required 1", ok);
    else passed++;
    bus_write(PIX + 32'd307199, 32'h3C, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL pix_last_ok got %b, required 1", ok);
    else passed++;
    idle(2);
    checks++;
    if (q_addr.size() != 2) $display("FAIL pix_count got %0d, required 2", q_addr.size());
    else passed++;
    if (q_addr.size() == 2) begin
      checks++;
      if (q_addr[0] !== 19'd5 || q_data[0] !== 8'hA7 || q_addr[1] !== 19'd307199 || q_data[1] !== 8'h3C)
        $display("FAIL pix_data got %0d/%h %0d/%h, required 5/a7 307199/3c",
                 q_addr[0], q_data[0], q_addr[1], q_data[1]);
      else passed++;
    end
    bus_read(PIX + 32'd5, d, ok);
    checks++;
    if (d !== 32'hFFFF_FFFF || ok !== 1'b0) $display("FAIL pix_read got %h/%b, required ffffffff/0", d, ok);
    else passed++;
  endtask

  task automatic test_busy_abort;
    logic [31:0] d;
    logic ok;
    int n;
    bus_write(32'h0C, 32'h0, ok);
    bus_write(32'h10, 32'h000A_0064, ok);
    q_addr.delete();
    q_data.delete();
    bus_write(32'h04, 32'h1, ok);
    bus_write(32'h04, 32'h1, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL busy_start_ok got %b, required 1", ok);
    else passed++;
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0005) $display("FAIL busy_status got %h, required 00020005", d);
    else passed++;
    bus_write(PIX + 32'd9, 32'h77, ok);
    checks++;
    if (ok !== 1'b0) $display("FAIL pix_busy_ok got %b, required 0", ok);
    else passed++;
    idle(1020);
    checks++;
    if (q_addr.size() != 1000 || q_addr[0] !== 19'd0 || q_addr[999] !== 19'd5859)
      $display("FAIL busy_fill got n=%0d, required 1000 writes 0..5859", q_addr.size());
    else passed++;
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0006) $display("FAIL busy_end_status got %h, required 00020006", d);
    else passed++;
    bus_write(32'h04, 32'h2, ok);
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0000) $display("FAIL err_clear got %h, required 00020000", d);
    else passed++;
    q_addr.delete();
    q_data.delete();
    bus_write(32'h04, 32'h1, ok);
    idle(5);
    bus_write(32'h04, 32'h4, ok);
    idle(5);
    n = q_addr.size();
    checks++;
    if (n == 0 || n >= 1000) $display("FAIL abort_count got %0d, required 1..999", n);
    else passed++;
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0000) $display("FAIL abort_status got %h, required 00020000", d);
    else passed++;
    idle(10);
    checks++;
    if (q_addr.size() != n) $display("FAIL abort_quiet got %0d, required %0d", q_addr.size(), n);
    else passed++;
  endtask

  task automatic test_clip;
    logic [31:0] d;
    logic ok;
    bus_write(32'h0C, 32'h0000_0276, ok);
    bus_write(32'h10, 32'h0001_0014, ok);
    q_addr.delete();
    q_data.delete();
    bus_write(32'h04, 32'h1, ok);
    idle(20);
    bus_read(32'h00, d, ok);
`ifdef GPU_FILL_CLIP_EN
    checks++;
    if (q_addr.size() != 10 || q_addr[0] !== 19'd630 || q_addr[9] !== 19'd639)
      $display("FAIL clip_writes got n=%0d, required 10 at 630..639", q_addr.size());
    else passed++;
    checks++;
    if (d !== 32'h0002_0002) $display("FAIL clip_status got %h, required 00020002", d);
    else passed++;
`else
    checks++;
    if (q_addr.size() != 0) $display("FAIL reject_writes got %0d, required 0", q_addr.size());
    else passed++;
    checks++;
    if (d !== 32'h0002_0004) $display("FAIL reject_status got %h, required 00020004", d);
    else passed++;
`endif
    bus_write(32'h04, 32'h2, ok);
    bus_write(32'h0C, 32'h0005_0005, ok);
    bus_write(32'h10, 32'h0005_0000, ok);
    bus_write(32'h04, 32'h1, ok);
    idle(5);
    bus_read(32'h00, d, ok);
    checks++;
    if (q_addr.size() != 0 || d !== 32'h0002_0002)
      $display("FAIL zero_w got n=%0d status=%h, required 0/00020002", q_addr.size(), d);
    else passed++;
    bus_write(32'h04, 32'h2, ok);
  endtask

  task automatic test_bad_addr;
    logic [31:0] d;
    logic ok;
    bus_read(32'h14, d, ok);
    checks++;
    if (d !== 32'hFFFF_FFFF || ok !== 1'b0) $display("FAIL read_0x14 got %h/%b, required ffffffff/0", d, ok);
    else passed++;
    bus_write(32'h14, 32'h1234, ok);
    checks++;
    if (ok !== 1'b0) $display("FAIL write_0x14 got %b, required 0", ok);
    else passed++;
    bus_read(32'h08, d, ok);
    checks++;
    if (d !== 32'h5A || ok !== 1'b1) $display("FAIL color_read got %h/%b, required 0000005a/1", d, ok);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int extra = 0;
    q_addr.delete();
    q_data.delete();
    @(negedge clk);
    read_address = 32'h00;
    read_processing_start = 1'b1;
    write_address = PIX + 32'd7;
    write_data = 32'h33;
    write_processing_start = 1'b1;
    @(negedge clk);
    checks++;
    if (read_processing_done !== 1'b1 || write_processing_done !== 1'b1)
      $display("FAIL same_cycle_done got rd=%b wr=%b, required 1/1", read_processing_done, write_processing_done);
    else passed++;
    checks++;
    if (read_data !== 32'h0002_0000 || read_resp_ok !== 1'b1 || write_processing_ok !== 1'b1)
      $display("FAIL same_cycle_data got %h/%b wok=%b, required 00020000/1 wok=1",
               read_data, read_resp_ok, write_processing_ok);
    else passed++;
    repeat (4) begin
      @(negedge clk);
      if (read_processing_done === 1'b1 || write_processing_done === 1'b1) extra++;
    end
    read_processing_start = 1'b0;
    write_processing_start = 1'b0;
    checks++;
    if (extra != 0) $display("FAIL no_retrigger got %0d extra pulses, required 0", extra);
    else passed++;
    checks++;
    if (q_addr.size() != 1 || q_addr[0] !== 19'd7 || q_data[0] !== 8'h33)
      $display("FAIL same_cycle_pixel got n=%0d, required 1 write 7/33", q_addr.size());
    else passed++;
  endtask

  task automatic test_reset_midfill;
    logic [31:0] d;
    logic ok;
    int n;
    bus_write(32'h0C, 32'h0, ok);
    bus_write(32'h10, 32'h000A_0064, ok);
    bus_write(32'h04, 32'h9, ok);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fbuf_en_wr !== 1'b0 || irq !== 1'b0 || fbuf_addr !== '0)
      $display("FAIL midfill_reset got en=%b irq=%b addr=%0d, required 0/0/0", fbuf_en_wr, irq, fbuf_addr);
    else passed++;
    n = q_addr.size();
    rst = 1'b0;
    idle(10);
    checks++;
    if (q_addr.size() != n) $display("FAIL midfill_quiet got %0d, required %0d", q_addr.size(), n);
    else passed++;
    bus_read(32'h00, d, ok);
    checks++;
    if (d !== 32'h0002_0000 || irq !== 1'b0) $display("FAIL midfill_status got %h irq=%b, required 00020000/0", d, irq);
    else passed++;
    bus_read(32'h04, d, ok);
    checks++;
    if (d !== 32'h0) $display("FAIL midfill_ctrl got %h, required 00000000", d);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_pixel();
    test_busy_abort();
    test_clip();
    test_bad_addr();
    test_back_to_back();
    test_reset_midfill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
